// File: rtl/alu_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// alu_arbiter_pkg
// Shared definitions for the two-port ALU arbiter:
//   - W_CPU / W_OPCODE : default datapath and function-code widths
//   - F_*              : ALU function codes (any other code yields res = 0)
//   - state_e          : arbiter FSM state encoding
//   - pick_winner()    : round-robin winner selection
// -----------------------------------------------------------------------------
package alu_arbiter_pkg;

  localparam int W_CPU    = 32;
  localparam int W_OPCODE = 4;

  localparam logic [W_OPCODE-1:0] F_ADD = 4'd0;
  localparam logic [W_OPCODE-1:0] F_SUB = 4'd1;
  localparam logic [W_OPCODE-1:0] F_AND = 4'd2;
  localparam logic [W_OPCODE-1:0] F_OR  = 4'd3;
  localparam logic [W_OPCODE-1:0] F_XOR = 4'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Returns the id of the requester to serve. The pointer only matters
  // when both ask at once; a lone requester always wins.
  function automatic logic pick_winner(input logic req0, input logic req1,
                                       input logic ptr);
    logic win;
    if (req0 && req1) win = ptr;
    else              win = req1;
    return win;
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// -----------------------------------------------------------------------------
// alu_arbiter_alu
// Purely combinational ALU shared by both requesters.
// Ports:
//   i_op   [WOP-1:0]  function code (F_ADD, F_SUB, F_AND, F_OR, F_XOR)
//   i_a    [W-1:0]    operand A
//   i_b    [W-1:0]    operand B
//   o_res  [W-1:0]    result (0 for unknown codes)
//   o_ovf             signed overflow of ADD/SUB, 0 otherwise
//   o_zero            result equals zero
// -----------------------------------------------------------------------------
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int W   = W_CPU,
  parameter int WOP = W_OPCODE
) (
  input  logic [WOP-1:0] i_op,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic [W-1:0]   o_res,
  output logic           o_ovf,
  output logic           o_zero
);

  logic [W-1:0] w_sum;
  logic [W-1:0] w_diff;

  assign w_sum  = i_a + i_b;
  assign w_diff = i_a - i_b;

  always_comb begin
    o_res = '0;
    o_ovf = 1'b0;
    case (i_op)
      F_ADD: begin
        o_res = w_sum;
        // Same-sign operands producing an opposite-sign sum
        o_ovf = (i_a[W-1] == i_b[W-1]) && (w_sum[W-1] != i_a[W-1]);
      end
      F_SUB: begin
        o_res = w_diff;
        // Opposite-sign operands where the difference flips sign away from A
        o_ovf = (i_a[W-1] != i_b[W-1]) && (w_diff[W-1] != i_a[W-1]);
      end
      F_AND:   o_res = i_a & i_b;
      F_OR:    o_res = i_a | i_b;
      F_XOR:   o_res = i_a ^ i_b;
      default: o_res = '0;
    endcase
  end

  assign o_zero = (o_res == '0);

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one ALU between two requesters with round-robin arbitration.
// One transaction in flight: IDLE (arbitrate + latch) -> EXEC (evaluate,
// register result) -> DONE (hold result until owner acks).
// Ports:
//   clk, rst_n              clock, async active-low reset
//   req0/req1               request strobes (sampled in IDLE only)
//   op0/op1, a0/b0, a1/b1   function codes and operands per requester
//   gnt0/gnt1               one-cycle pulse: operands captured
//   ack0/ack1               result consumed (owner only, DONE only)
//   vld0/vld1               result on res belongs to that requester
//   res, res_ovf, res_zero  registered ALU result and flags
//   busy                    FSM not in IDLE
//   dbg_state               current FSM state encoding (state_e)
// Handshake: a requester holds req/op/operands until its gnt pulse; after
// vld rises it presents ack, and the edge that samples ack with vld high
// completes the transfer and returns the FSM to IDLE.
// -----------------------------------------------------------------------------
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int W   = W_CPU,
  parameter int WOP = W_OPCODE
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0,
  input  logic           req1,
  input  logic [WOP-1:0] op0,
  input  logic [WOP-1:0] op1,
  input  logic [W-1:0]   a0,
  input  logic [W-1:0]   b0,
  input  logic [W-1:0]   a1,
  input  logic [W-1:0]   b1,
  output logic           gnt0,
  output logic           gnt1,
  input  logic           ack0,
  input  logic           ack1,
  output logic           vld0,
  output logic           vld1,
  output logic [W-1:0]   res,
  output logic           res_ovf,
  output logic           res_zero,
  output logic           busy,
  output logic [1:0]     dbg_state
);

  state_e         r_state;
  logic           r_ptr;
  logic           r_owner;
  logic [WOP-1:0] r_op;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic           r_gnt0;
  logic           r_gnt1;
  logic           r_vld0;
  logic           r_vld1;
  logic [W-1:0]   r_res;
  logic           r_ovf;
  logic           r_zero;

  logic           w_win;
  logic           w_owner_ack;
  logic [W-1:0]   w_alu_res;
  logic           w_alu_ovf;
  logic           w_alu_zero;

  assign w_win       = pick_winner(req0, req1, r_ptr);
  assign w_owner_ack = r_owner ? ack1 : ack0;

  alu_arbiter_alu #(
    .W   (W),
    .WOP (WOP)
  ) u_alu (
    .i_op   (r_op),
    .i_a    (r_a),
    .i_b    (r_b),
    .o_res  (w_alu_res),
    .o_ovf  (w_alu_ovf),
    .o_zero (w_alu_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= 1'b0;
      r_owner <= 1'b0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_vld0  <= 1'b0;
      r_vld1  <= 1'b0;
      r_res   <= '0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      // Grants are single-cycle pulses; only IDLE can raise them again.
      r_gnt0 <= 1'b0;
      r_gnt1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req0 || req1) begin
            r_owner <= w_win;
            r_op    <= w_win ? op1 : op0;
            r_a     <= w_win ? a1  : a0;
            r_b     <= w_win ? b1  : b0;
            r_gnt0  <= ~w_win;
            r_gnt1  <= w_win;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_res   <= w_alu_res;
          r_ovf   <= w_alu_ovf;
          r_zero  <= w_alu_zero;
          r_vld0  <= ~r_owner;
          r_vld1  <= r_owner;
          r_state <= S_DONE;
        end
        S_DONE: begin
          if (w_owner_ack) begin
            r_vld0  <= 1'b0;
            r_vld1  <= 1'b0;
            r_ptr   <= ~r_owner;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt0      = r_gnt0;
  assign gnt1      = r_gnt1;
  assign vld0      = r_vld0;
  assign vld1      = r_vld1;
  assign res       = r_res;
  assign res_ovf   = r_ovf;
  assign res_zero  = r_zero;
  assign busy      = (r_state != S_IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int W   = W_CPU;
  localparam int WOP = W_OPCODE;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic           req0, req1, ack0, ack1;
  logic [WOP-1:0] op0, op1;
  logic [W-1:0]   a0, b0, a1, b1;
  logic           gnt0, gnt1, vld0, vld1, res_ovf, res_zero, busy;
  logic [W-1:0]   res;
  logic [1:0]     dbg_state;

  alu_arbiter #(.W(W), .WOP(WOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1),
    .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1),
    .ack0(ack0), .ack1(ack1),
    .vld0(vld0), .vld1(vld1),
    .res(res), .res_ovf(res_ovf), .res_zero(res_zero),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int m_ptr    = 0;            // model: requester favoured on a tie
  logic [W+1:0] exp_q[$];      // {ovf, zero, res} per granted transaction

  typedef struct {
    int             port;
    logic [WOP-1:0] op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [W-1:0]   res;
    logic           ovf;
    logic           zero;
  } vec_t;
  vec_t tbl[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference ALU from signed integer arithmetic.
  function automatic logic [W+1:0] model(input logic [WOP-1:0] op,
                                         input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, s, maxv, minv;
    logic [W-1:0] r;
    logic o;
    sa = $signed(a);
    sb = $signed(b);
    maxv = (longint'(1) <<< (W-1)) - 1;
    minv = -(longint'(1) <<< (W-1));
    r = '0;
    o = 1'b0;
    case (op)
      F_ADD: begin s = sa + sb; r = W'(s); o = (s > maxv) || (s < minv); end
      F_SUB: begin s = sa - sb; r = W'(s); o = (s > maxv) || (s < minv); end
      F_AND: r = a & b;
      F_OR:  r = a | b;
      F_XOR: r = a ^ b;
      default: r = '0;
    endcase
    return {o, (r == '0), r};
  endfunction

  function automatic logic [W-1:0] rand_val();
    logic [W-1:0] v;
    case ($urandom_range(0, 4))
      0: v = {1'b0, {(W-1){1'b1}}};
      1: v = {1'b1, {(W-1){1'b0}}};
      2: v = W'($urandom_range(0, 3));
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    rst_n = 1'b0;
    req0 = 0; req1 = 0; ack0 = 0; ack1 = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_ptr = 0;
  endtask

  task automatic set_port(input int p, input logic [WOP-1:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b);
    if (p == 0) begin req0 = 1; op0 = op; a0 = a; b0 = b; end
    else        begin req1 = 1; op1 = op; a1 = a; b1 = b; end
  endtask

  // Serve one transaction. Called just after a rising edge with requests
  // already driven; returns just after the edge that completes the ack.
  task automatic serve(input int exp_port, input logic [W-1:0] e_res,
                       input logic e_ovf, input logic e_zero,
                       input int ack_wait, input bit keep_req, input bit poke);
    int n;
    int got;
    logic [W+1:0] e;
    logic [W-1:0] hold;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!(gnt0 || gnt1) && n < 20);
    if (!(gnt0 || gnt1)) begin
      check("gnt_timeout", 64'(n), 64'd1);
      return;
    end
    check("gnt_latency", 64'(n), 64'd1);
    got = gnt1 ? 1 : 0;
    check("gnt_port", 64'(got), 64'(exp_port));
    check("gnt_excl", 64'(gnt0 & gnt1), 64'd0);
    check("busy_exec", 64'(busy), 64'd1);
    exp_q.push_back({e_ovf, e_zero, e_res});
    if (!keep_req) begin
      if (got == 0) req0 = 0; else req1 = 0;
    end
    @(posedge clk); #1;
    e = exp_q.pop_front();
    check("gnt_pulse", 64'(gnt0 | gnt1), 64'd0);
    check("vld_owner", 64'({vld1, vld0}), (exp_port == 1) ? 64'd2 : 64'd1);
    check("res", 64'(res), 64'(e[W-1:0]));
    check("res_ovf", 64'(res_ovf), 64'(e[W+1]));
    check("res_zero", 64'(res_zero), 64'(e[W]));
    hold = res;
    for (int i = 0; i < ack_wait; i++) begin
      if (poke) begin
        if (got == 0) ack1 = 1; else ack0 = 1;
      end
      @(posedge clk); #1;
      ack0 = 0; ack1 = 0;
      check("vld_hold", 64'(vld0 | vld1), 64'd1);
      check("res_hold", 64'(res), 64'(hold));
      check("state_done", 64'(dbg_state), 64'(S_DONE));
    end
    if (got == 0) ack0 = 1; else ack1 = 1;
    @(posedge clk); #1;
    ack0 = 0; ack1 = 0;
    check("vld_drop", 64'({vld1, vld0}), 64'd0);
    check("busy_idle", 64'(busy), 64'd0);
    m_ptr = 1 - exp_port;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [W+1:0] m;
    tbl[0]  = '{0, F_ADD, 32'd5,        32'd7,        32'd12,       1'b0, 1'b0};
    tbl[1]  = '{1, F_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0};
    tbl[2]  = '{0, F_SUB, 32'd9,        32'd9,        32'd0,        1'b0, 1'b1};
    tbl[3]  = '{1, F_SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0};
    tbl[4]  = '{0, F_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b1};
    tbl[5]  = '{1, F_AND, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 1'b0};
    tbl[6]  = '{0, F_OR,  32'h0000000F, 32'h000000F0, 32'h000000FF, 1'b0, 1'b0};
    tbl[7]  = '{1, F_XOR, 32'hAAAA5555, 32'hFFFFFFFF, 32'h5555AAAA, 1'b0, 1'b0};
    tbl[8]  = '{0, 4'd7,  32'd3,        32'd4,        32'd0,        1'b0, 1'b1};
    tbl[9]  = '{1, F_ADD, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1};
    tbl[10] = '{0, F_SUB, 32'd0,        32'd1,        32'hFFFFFFFF, 1'b0, 1'b0};

    op0 = '0; op1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    apply_reset();

    // Reset state
    check("rst_gnt",  64'({gnt1, gnt0}), 64'd0);
    check("rst_vld",  64'({vld1, vld0}), 64'd0);
    check("rst_res",  64'(res), 64'd0);
    check("rst_ovf",  64'(res_ovf), 64'd0);
    check("rst_zero", 64'(res_zero), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);

    // Simultaneous request straight after reset: port 0 first, then port 1
    set_port(0, F_SUB, 32'd9, 32'd9);
    set_port(1, F_ADD, 32'd1, 32'd2);
    serve(0, 32'd0, 1'b0, 1'b1, 0, 0, 0);
    serve(1, 32'd3, 1'b0, 1'b0, 0, 0, 0);

    // Directed vectors, single requester each
    for (int i = 0; i < 11; i++) begin
      set_port(tbl[i].port, tbl[i].op, tbl[i].a, tbl[i].b);
      serve(tbl[i].port, tbl[i].res, tbl[i].ovf, tbl[i].zero, 0, 0, 0);
    end

    // Owner ack withheld 5 cycles while the other side pulses ack
    set_port(0, F_ADD, 32'd100, 32'd23);
    serve(0, 32'd123, 1'b0, 1'b0, 5, 0, 1);

    // Both requesters held high, immediate ack: grants alternate from port 0
    apply_reset();
    set_port(0, F_ADD, 32'd40, 32'd2);
    set_port(1, F_XOR, 32'h0000FFFF, 32'h000000FF);
    for (int i = 0; i < 8; i++) begin
      m = (m_ptr == 1) ? model(op1, a1, b1) : model(op0, a0, b0);
      check("alt_expect", 64'(m_ptr), 64'(i % 2));
      serve(m_ptr, m[W-1:0], m[W+1], m[W], 0, 1, 0);
    end
    req0 = 0; req1 = 0;
    @(posedge clk); #1;

    // Reset pulse while DONE on port 1
    set_port(1, F_ADD, 32'd1, 32'd1);
    @(posedge clk); #1;
    check("r37_gnt", 64'(gnt1), 64'd1);
    req1 = 0;
    @(posedge clk); #1;
    check("r37_vld_pre", 64'(vld1), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("r37_vld", 64'({vld1, vld0}), 64'd0);
    check("r37_busy", 64'(busy), 64'd0);
    check("r37_res", 64'(res), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    m_ptr = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("r37_no_vld", 64'({vld1, vld0}), 64'd0);
    end
    set_port(0, F_OR, 32'h10, 32'h01);
    set_port(1, F_AND, 32'h3, 32'h1);
    serve(0, 32'h11, 1'b0, 1'b0, 0, 0, 0);
    serve(1, 32'h1, 1'b0, 1'b0, 0, 0, 0);

    // Randomized traffic against the reference model
    for (int t = 0; t < 60; t++) begin
      int pat;
      int win;
      pat = $urandom_range(1, 3);
      if (pat[0] && !req0) set_port(0, WOP'($urandom_range(0, 7)), rand_val(), rand_val());
      if (pat[1] && !req1) set_port(1, WOP'($urandom_range(0, 7)), rand_val(), rand_val());
      win = (req0 && req1) ? m_ptr : (req1 ? 1 : 0);
      m = (win == 1) ? model(op1, a1, b1) : model(op0, a0, b0);
      serve(win, m[W-1:0], m[W+1], m[W], $urandom_range(0, 3), 0, 1'($urandom_range(0, 1)));
    end
    if (req0 || req1) begin
      m = req1 ? model(op1, a1, b1) : model(op0, a0, b0);
      serve(req1 ? 1 : 0, m[W-1:0], m[W+1], m[W], 0, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
